// File: rtl/register_file_pkg.sv
// Shared constants for the 16 x 32-bit register file: sizes, the PC register
// index and increment, and symbolic register indices.
package register_file_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 4;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
    localparam int PC_INDEX   = 15;
    localparam int PC_STEP    = 4;

    localparam logic [ADDR_WIDTH-1:0] PC_SEL  = ADDR_WIDTH'(PC_INDEX);
    localparam logic [DATA_WIDTH-1:0] PC_INCR = DATA_WIDTH'(PC_STEP);

    localparam logic [ADDR_WIDTH-1:0] R0  = 4'd0;
    localparam logic [ADDR_WIDTH-1:0] R1  = 4'd1;
    localparam logic [ADDR_WIDTH-1:0] R2  = 4'd2;
    localparam logic [ADDR_WIDTH-1:0] R3  = 4'd3;
    localparam logic [ADDR_WIDTH-1:0] R4  = 4'd4;
    localparam logic [ADDR_WIDTH-1:0] R5  = 4'd5;
    localparam logic [ADDR_WIDTH-1:0] R6  = 4'd6;
    localparam logic [ADDR_WIDTH-1:0] R7  = 4'd7;
    localparam logic [ADDR_WIDTH-1:0] R8  = 4'd8;
    localparam logic [ADDR_WIDTH-1:0] R9  = 4'd9;
    localparam logic [ADDR_WIDTH-1:0] R10 = 4'd10;
    localparam logic [ADDR_WIDTH-1:0] R11 = 4'd11;
    localparam logic [ADDR_WIDTH-1:0] R12 = 4'd12;
    localparam logic [ADDR_WIDTH-1:0] R13 = 4'd13;
    localparam logic [ADDR_WIDTH-1:0] R14 = 4'd14;
    localparam logic [ADDR_WIDTH-1:0] R15 = 4'd15;

    // One-hot write-select decode.
    function automatic logic [NUM_REGS-1:0] decode_sel(input logic [ADDR_WIDTH-1:0] sel);
        decode_sel = NUM_REGS'(1) << sel;
    endfunction

endpackage

// File: rtl/register_file_reg_32_bit_sync.sv
// Single data register with synchronous active-low clear and load enable;
// the general-purpose registers R0..R14 are built from this cell.
module reg_32_bit_sync
    import register_file_pkg::*;
(
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  load_enable,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!clr) begin
            q <= '0;
        end else if (load_enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file.sv
// 16 x 32-bit register file: two combinational read ports with write bypass,
// one write port, and R15 acting as the program counter.
module register_file
    import register_file_pkg::*;
(
    input  logic                  clk,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:0] ra_sel,
    input  logic [ADDR_WIDTH-1:0] rb_sel,
    output logic [DATA_WIDTH-1:0] ra_out,
    output logic [DATA_WIDTH-1:0] rb_out,
    input  logic [ADDR_WIDTH-1:0] rd_sel,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] pc_in,
    input  logic                  pc_load,
    input  logic                  pc_enable,
    output logic [DATA_WIDTH-1:0] pc_out
);

    logic [NUM_REGS-1:0]   wr_onehot;
    logic [DATA_WIDTH-1:0] rf_view [NUM_REGS];
    logic [DATA_WIDTH-1:0] pc_reg;
    logic                  bypass_a;
    logic                  bypass_b;

    assign wr_onehot = write_enable ? decode_sel(rd_sel) : '0;

    genvar i;
    generate
        for (i = 0; i < PC_INDEX; i++) begin : g_gpr
            reg_32_bit_sync u_reg (
                .clk         (clk),
                .clr         (clr),
                .load_enable (wr_onehot[i]),
                .d           (write_data),
                .q           (rf_view[i])
            );
        end
    endgenerate

    // Branch load beats a writeback to R15, which beats the fetch increment.
    always_ff @(posedge clk) begin
        if (!clr) begin
            pc_reg <= '0;
        end else if (pc_load) begin
            pc_reg <= pc_in;
        end else if (wr_onehot[PC_INDEX]) begin
            pc_reg <= write_data;
        end else if (pc_enable) begin
            pc_reg <= pc_reg + PC_INCR;
        end
    end

    assign rf_view[PC_INDEX] = pc_reg;
    assign pc_out            = pc_reg;

    // Bypass only when this edge's write really lands; a pending branch load
    // wins over a writeback to R15, so that case shows the stored PC instead.
    always_comb begin
        bypass_a = clr && write_enable && (rd_sel == ra_sel) && !((ra_sel == PC_SEL) && pc_load);
        bypass_b = clr && write_enable && (rd_sel == rb_sel) && !((rb_sel == PC_SEL) && pc_load);
        ra_out   = bypass_a ? write_data : rf_view[ra_sel];
        rb_out   = bypass_b ? write_data : rf_view[rb_sel];
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by random
// traffic, all compared against an array-based reference model.
module tb_register_file;

    logic        clk;
    logic        clr;
    logic [3:0]  ra_sel;
    logic [3:0]  rb_sel;
    logic [31:0] ra_out;
    logic [31:0] rb_out;
    logic [3:0]  rd_sel;
    logic [31:0] write_data;
    logic        write_enable;
    logic [31:0] pc_in;
    logic        pc_load;
    logic        pc_enable;
    logic [31:0] pc_out;

    logic [31:0] model [16];
    int          n_compared   = 0;
    int          n_mismatched = 0;

    register_file dut (
        .clk          (clk),
        .clr          (clr),
        .ra_sel       (ra_sel),
        .rb_sel       (rb_sel),
        .ra_out       (ra_out),
        .rb_out       (rb_out),
        .rd_sel       (rd_sel),
        .write_data   (write_data),
        .write_enable (write_enable),
        .pc_in        (pc_in),
        .pc_load      (pc_load),
        .pc_enable    (pc_enable),
        .pc_out       (pc_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Expected read value given the model contents and the inputs currently applied.
    function automatic logic [31:0] model_read(input logic [3:0] sel);
        if (clr && write_enable && rd_sel == sel && !(sel == 4'd15 && pc_load))
            return write_data;
        return model[sel];
    endfunction

    function automatic void model_step();
        logic [31:0] next_pc;
        if (!clr) begin
            for (int k = 0; k < 16; k++) model[k] = 32'h0;
            return;
        end
        next_pc = model[15];
        if (pc_load)                              next_pc = pc_in;
        else if (write_enable && rd_sel == 4'd15) next_pc = write_data;
        else if (pc_enable)                       next_pc = model[15] + 32'd4;
        if (write_enable && rd_sel != 4'd15) model[rd_sel] = write_data;
        model[15] = next_pc;
    endfunction

    task automatic applyStimulus(input logic c, input logic [3:0] ra, input logic [3:0] rb,
                                 input logic [3:0] rd, input logic [31:0] wd, input logic we,
                                 input logic [31:0] pi, input logic pl, input logic pe);
        clr = c; ra_sel = ra; rb_sel = rb; rd_sel = rd; write_data = wd;
        write_enable = we; pc_in = pi; pc_load = pl; pc_enable = pe;
        #1;
        checkOutput("ra_out_pre", ra_out, model_read(ra_sel));
        checkOutput("rb_out_pre", rb_out, model_read(rb_sel));
        checkOutput("pc_out_pre", pc_out, model[15]);
        @(posedge clk);
        model_step();
        #1;
        checkOutput("pc_out_post", pc_out, model[15]);
    endtask

    initial begin
        clr = 1'b0; ra_sel = 4'd0; rb_sel = 4'd0; rd_sel = 4'd0; write_data = 32'h0;
        write_enable = 1'b0; pc_in = 32'h0; pc_load = 1'b0; pc_enable = 1'b0;
        for (int k = 0; k < 16; k++) model[k] = 32'h0;

        // Reset held two edges with a write attempt to R3 present.
        rd_sel = 4'd3; write_data = 32'hDEADBEEF; write_enable = 1'b1; ra_sel = 4'd3;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 4'd3, 4'd15, 4'd3, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 1'b0);
        checkOutput("reset_r3", ra_out, 32'h0);
        checkOutput("reset_pc", pc_out, 32'h0);

        // Write R1 and R2 on consecutive edges, then read them back.
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd1, 32'h0000000A, 1'b1, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd1, 4'd2, 4'd2, 32'h0000000B, 1'b1, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd1, 4'd2, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("read_r1", ra_out, 32'h0000000A);
        checkOutput("read_r2", rb_out, 32'h0000000B);
        applyStimulus(1'b1, 4'd4, 4'd4, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("read_r4_unwritten", ra_out, 32'h0);

        // Same-cycle bypass on R5, then the stored value after the edge.
        clr = 1'b1; write_enable = 1'b1; rd_sel = 4'd5; write_data = 32'h0000000C; ra_sel = 4'd5;
        #1;
        checkOutput("bypass_r5", ra_out, 32'h0000000C);
        applyStimulus(1'b1, 4'd5, 4'd5, 4'd5, 32'h0000000C, 1'b1, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd5, 4'd0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("hold_r5", ra_out, 32'h0000000C);

        // PC increments, then load beats R15 write beats increment.
        applyStimulus(1'b1, 4'd0, 4'd15, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("pc_inc1", pc_out, 32'd4);
        applyStimulus(1'b1, 4'd0, 4'd15, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("pc_inc2", pc_out, 32'd8);
        applyStimulus(1'b1, 4'd0, 4'd15, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("pc_inc3", pc_out, 32'd12);
        clr = 1'b1; pc_load = 1'b1; pc_in = 32'h100; write_enable = 1'b1; rd_sel = 4'd15;
        write_data = 32'h200; pc_enable = 1'b1; rb_sel = 4'd15;
        #1;
        checkOutput("pc_no_bypass", rb_out, 32'd12);
        applyStimulus(1'b1, 4'd0, 4'd15, 4'd15, 32'h200, 1'b1, 32'h100, 1'b1, 1'b1);
        checkOutput("pc_load_prio", pc_out, 32'h100);
        applyStimulus(1'b1, 4'd15, 4'd15, 4'd15, 32'h200, 1'b1, 32'h0, 1'b0, 1'b1);
        checkOutput("pc_write_prio", pc_out, 32'h200);

        // Wraparound of the increment.
        applyStimulus(1'b1, 4'd0, 4'd15, 4'd0, 32'h0, 1'b0, 32'hFFFFFFFC, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'd0, 4'd15, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("pc_wrap", pc_out, 32'h0);

        // Reset mid-operation, then increment resumes from zero.
        applyStimulus(1'b1, 4'd6, 4'd15, 4'd6, 32'h12345678, 1'b1, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd6, 4'd5, 4'd7, 32'h87654321, 1'b1, 32'h0, 1'b0, 1'b1);
        checkOutput("midreset_pc", pc_out, 32'h0);
        checkOutput("midreset_r6", ra_out, 32'h0);
        checkOutput("midreset_r5", rb_out, 32'h0);
        applyStimulus(1'b1, 4'd0, 4'd15, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("resume_pc", pc_out, 32'd4);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            applyStimulus(($urandom_range(0, 31) != 0),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), $urandom(),
                          ($urandom_range(0, 2) != 0), $urandom(),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1));
        end

        // Final read-out of every register.
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, 4'(k), 4'(15 - k), 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
